// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter
// ----------------
// Byte-wide SPI master data path. It sits next to spi_clock_generator and is
// driven by that block's leading/trailing edge pulses. It shifts one TX byte
// out on MOSI and assembles one RX byte from MISO per transaction.
//
// Parameters:
//   SPI_MODE : 0..3. Only CPHA (modes 1 and 3) matters here; CPOL is handled
//              entirely by the clock generator.
//
// Build option:
//   SPI_LSB_FIRST_EN : when defined, TX and RX are LSB-first. Otherwise they
//                      are MSB-first. Edge counting, latency and handshake are
//                      identical in both builds.
//
// Ports:
//   i_Clk, i_Rst      : clock, synchronous active-high reset
//   i_TX_Byte/i_TX_DV : byte to send plus a single-cycle start pulse. It is
//                       accepted only in IDLE.
//   o_Busy            : high from the cycle after a start until o_RX_DV
//   i_Leading_Edge    : one-cycle SCLK leading-edge pulse
//   i_Trailing_Edge   : one-cycle SCLK trailing-edge pulse
//   o_SPI_MOSI        : serial data out
//   i_SPI_MISO        : serial data in. It must already be synchronised.
//   o_RX_Byte/o_RX_DV : received byte and its one-cycle valid pulse
module spi_byte_shifter #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_Busy,
    input  logic       i_Leading_Edge,
    input  logic       i_Trailing_Edge,
    output logic       o_SPI_MOSI,
    input  logic       i_SPI_MISO,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV
);

    localparam bit CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

`ifdef SPI_LSB_FIRST_EN
    localparam logic [2:0] IDX_FIRST  = 3'd0;
    localparam logic [2:0] IDX_SECOND = 3'd1;
    localparam logic [2:0] IDX_LAST   = 3'd7;
`else
    localparam logic [2:0] IDX_FIRST  = 3'd7;
    localparam logic [2:0] IDX_SECOND = 3'd6;
    localparam logic [2:0] IDX_LAST   = 3'd0;
`endif

    // Advance a bit index toward the last bit. The index saturates at the
    // last bit so it never wraps inside a transfer. Completion is decided by
    // the trailing-edge counter, not by the index.
    function automatic logic [2:0] idx_step(input logic [2:0] idx);
        if (idx == IDX_LAST) return idx;
`ifdef SPI_LSB_FIRST_EN
        return idx + 3'd1;
`else
        return idx - 3'd1;
`endif
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tx_reg_q, tx_reg_d;
    logic [7:0] rx_reg_q, rx_reg_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic [2:0] rx_idx_q, rx_idx_d;
    logic [3:0] edge_cnt_q, edge_cnt_d;
    logic       mosi_q, mosi_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        tx_reg_d   = tx_reg_q;
        rx_reg_d   = rx_reg_q;
        tx_idx_d   = tx_idx_q;
        rx_idx_d   = rx_idx_q;
        edge_cnt_d = edge_cnt_q;
        mosi_d     = mosi_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (i_TX_DV) begin
                    tx_reg_d   = i_TX_Byte;
                    tx_idx_d   = IDX_FIRST;
                    rx_idx_d   = IDX_FIRST;
                    edge_cnt_d = 4'd0;
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                    // CPHA=0 samples on the first leading edge, so the first
                    // bit must already be on the wire before it.
                    if (!CPHA) begin
                        mosi_d   = i_TX_Byte[IDX_FIRST];
                        tx_idx_d = IDX_SECOND;
                    end
                end
            end

            S_SHIFT: begin
                // The leading edge is handled before the trailing edge. The
                // trailing branch builds on the *_d values, so a coincident
                // pair behaves as leading-then-trailing.
                if (i_Leading_Edge) begin
                    if (!CPHA) begin
                        rx_reg_d[rx_idx_d] = i_SPI_MISO;
                        rx_idx_d           = idx_step(rx_idx_d);
                    end else begin
                        mosi_d   = tx_reg_d[tx_idx_d];
                        tx_idx_d = idx_step(tx_idx_d);
                    end
                end
                if (i_Trailing_Edge) begin
                    if (!CPHA) begin
                        // Seven trailing edges carry bits 2..8. The eighth
                        // trailing edge only ends the transfer.
                        if (edge_cnt_q < 4'd7) begin
                            mosi_d   = tx_reg_d[tx_idx_d];
                            tx_idx_d = idx_step(tx_idx_d);
                        end
                    end else begin
                        rx_reg_d[rx_idx_d] = i_SPI_MISO;
                        rx_idx_d           = idx_step(rx_idx_d);
                    end
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q == 4'd7) state_d = S_DONE;
                end
            end

            S_DONE: begin
                rx_byte_d = rx_reg_q;
                rx_dv_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= S_IDLE;
            tx_reg_q   <= 8'h00;
            rx_reg_q   <= 8'h00;
            tx_idx_q   <= 3'd7;
            rx_idx_q   <= 3'd7;
            edge_cnt_q <= 4'd0;
            mosi_q     <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_dv_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_reg_q   <= tx_reg_d;
            rx_reg_q   <= rx_reg_d;
            tx_idx_q   <= tx_idx_d;
            rx_idx_q   <= rx_idx_d;
            edge_cnt_q <= edge_cnt_d;
            mosi_q     <= mosi_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
            busy_q     <= busy_d;
        end
    end

    assign o_Busy     = busy_q;
    assign o_SPI_MOSI = mosi_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_RX_DV    = rx_dv_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Testbench for spi_byte_shifter. It uses two instances that share all
// stimulus: index 0 is SPI_MODE=0 (CPHA=0) and index 1 is SPI_MODE=1
// (CPHA=1). The bench generates the edge pulses the way the clock generator
// would.
module tb_spi_byte_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, tx_dv, lead, trail, miso_r;
    logic [7:0]      tx_byte;
    logic [1:0]      mosi, miso, busy, rx_dv;
    logic [1:0][7:0] rx_byte;
    int              miso_mode; // 0 loopback, 1 random, 2 tied high
    int              cyc = 0;
    int              n_chk = 0, n_fail = 0;

    typedef struct {
        logic [7:0] rx;
        int         cyc;
    } exp_t;
    exp_t q0[$], q1[$];

    logic [7:0] last_rx0, last_rx1;
    logic       last_mosi;

    assign miso[0] = (miso_mode == 0) ? mosi[0] : miso_r;
    assign miso[1] = (miso_mode == 0) ? mosi[1] : miso_r;

    spi_byte_shifter #(.SPI_MODE(0)) u_m0 (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv),
        .o_Busy(busy[0]), .i_Leading_Edge(lead), .i_Trailing_Edge(trail),
        .o_SPI_MOSI(mosi[0]), .i_SPI_MISO(miso[0]),
        .o_RX_Byte(rx_byte[0]), .o_RX_DV(rx_dv[0])
    );

    spi_byte_shifter #(.SPI_MODE(1)) u_m1 (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv),
        .o_Busy(busy[1]), .i_Leading_Edge(lead), .i_Trailing_Edge(trail),
        .o_SPI_MOSI(mosi[1]), .i_SPI_MISO(miso[1]),
        .o_RX_Byte(rx_byte[1]), .o_RX_DV(rx_dv[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Wire position of the k-th transmitted/received bit.
    function automatic int bitpos(input int k);
`ifdef SPI_LSB_FIRST_EN
        return k;
`else
        return 7 - k;
`endif
    endfunction

    function automatic logic next_miso(input int mode);
        return (mode == 2) ? 1'b1 : 1'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every o_RX_DV pulse must match a queued expectation.
    task automatic pop_chk(input int i);
        exp_t e;
        if (i == 0 && q0.size() != 0) e = q0.pop_front();
        else if (i == 1 && q1.size() != 0) e = q1.pop_front();
        else begin
            check("unexpected_rx_dv", 32'(i) + 32'd1, 32'd0);
            return;
        end
        check("rx_byte", rx_byte[i], e.rx);
        check("rx_dv_latency", cyc, e.cyc);
        check("busy_low_at_rx_dv", busy[i], 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && rx_dv[0]) pop_chk(0);
        if (!rst && rx_dv[1]) pop_chk(1);
    end

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_mosi0"}, mosi[0], last_mosi);
        check({tag, "_mosi1"}, mosi[1], last_mosi);
        check({tag, "_rx0"}, rx_byte[0], last_rx0);
        check({tag, "_rx1"}, rx_byte[1], last_rx1);
        check({tag, "_busy0"}, busy[0], 1'b0);
        check({tag, "_busy1"}, busy[1], 1'b0);
    endtask

    // One transfer, emulating the clock generator with 'half' cycles per
    // SCLK half period. abort_k>0 pulses reset after that many leading edges.
    // inj_k in 0..7 re-pulses i_TX_DV with 8'h00 on that leading edge. The
    // task returns in the o_RX_DV cycle, so an immediate call is back-to-back.
    task automatic xfer(input logic [7:0] tx, input int half, input int mode,
                        input int abort_k, input int inj_k);
        logic [7:0] e0, e1;
        exp_t       e;
        e0 = 8'h00;
        e1 = 8'h00;
        miso_mode = mode;
        tx_byte = tx;
        tx_dv   = 1'b1;
        tick();
        tx_dv   = 1'b0;
        tx_byte = 8'($urandom);
        check("busy_after_start0", busy[0], 1'b1);
        check("busy_after_start1", busy[1], 1'b1);
        for (int k = 0; k < 8; k++) begin
            repeat (half - 1) begin miso_r = next_miso(mode); tick(); end
            miso_r = next_miso(mode);
            lead   = 1'b1;
            if (k == inj_k) begin tx_dv = 1'b1; tx_byte = 8'h00; end
            // CPHA=0 slave samples on the leading edge.
            check("mosi_at_lead_cpha0", mosi[0], tx[bitpos(k)]);
            e0[bitpos(k)] = (mode == 0) ? tx[bitpos(k)] : miso_r;
            tick();
            lead  = 1'b0;
            tx_dv = 1'b0;
            if (k + 1 == abort_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                last_rx0  = 8'h00;
                last_rx1  = 8'h00;
                last_mosi = 1'b0;
                chk_idle_outputs("after_abort");
                miso_mode = 0;
                return;
            end
            repeat (half - 1) begin miso_r = next_miso(mode); tick(); end
            miso_r = next_miso(mode);
            trail  = 1'b1;
            // CPHA=1 slave samples on the trailing edge.
            check("mosi_at_trail_cpha1", mosi[1], tx[bitpos(k)]);
            e1[bitpos(k)] = (mode == 0) ? tx[bitpos(k)] : miso_r;
            if (k == 7) begin
                e.rx = e0; e.cyc = cyc + 2; q0.push_back(e);
                e.rx = e1; e.cyc = cyc + 2; q1.push_back(e);
            end
            tick();
            trail = 1'b0;
        end
        tick();
        last_rx0  = e0;
        last_rx1  = e1;
        last_mosi = tx[bitpos(7)];
    endtask

    initial begin
        rst = 1'b1; tx_dv = 1'b0; lead = 1'b0; trail = 1'b0; miso_r = 1'b0;
        tx_byte = 8'h00; miso_mode = 0;
        last_rx0 = 8'h00; last_rx1 = 8'h00; last_mosi = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_idle_outputs("reset");
        check("reset_rx_dv", rx_dv, 2'b00);

        // Directed cases.
        xfer(8'hA5, 2, 0, 0, -1);
        repeat (3) tick();
        xfer(8'h3C, 2, 2, 0, -1);
        repeat (2) tick();
        xfer(8'hF0, 2, 0, 3, -1);
        repeat (2) tick();
        xfer(8'h81, 2, 0, 0, -1);
        repeat (2) tick();
        xfer(8'h5A, 3, 0, 0, 3);
        xfer(8'hC3, 2, 0, 0, -1);
        xfer(8'h01, 1, 0, 0, -1);
        repeat (3) tick();

        // Edge pulses with no transfer in flight must do nothing.
        for (int i = 0; i < 6; i++) begin
            miso_r = 1'($urandom);
            lead = 1'b1; tick(); lead = 1'b0;
            trail = 1'b1; tick(); trail = 1'b0;
        end
        lead = 1'b1; trail = 1'b1; tick(); lead = 1'b0; trail = 1'b0;
        repeat (3) tick();
        chk_idle_outputs("idle_edges");

        // Randomised transfers.
        for (int n = 0; n < 24; n++) begin
            xfer(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                 0, int'($urandom_range(0, 11)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
        end
        repeat (5) tick();
        chk_idle_outputs("final");
        check("pending_rx_dv", 32'(q0.size() + q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
